apb_slave_ws_mem: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 17 +
 rtl/apb_slv_mem.sv | 41 ++++
 rtl/apb_slave_ws_mem.sv | 153 +++++++++++++++
 tb/tb_apb_slave_ws_mem.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the wait-state APB slave.
// FSM encoding, wait counter width and byte-offset sizing.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int WAIT_W = 4;

  function automatic int off_w(input int dw);
    return (dw == 8)  ? 0 :
           (dw == 16) ? 1 : 2;
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// Word storage for the APB slave: async clear,
// byte-enabled write port, combinational read port.
module apb_slv_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int MI_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MI_W-1:0]   widx,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MI_W-1:0]   ridx,
  output logic [DATA_W-1:0] rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear on reset, otherwise merge enabled bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_ws_mem.sv
// APB slave with wait states, error response and word memory.
// Byte-strobe writes when APB_SLAVE_WS_MEM_PSTRB_EN is defined.
module apb_slave_ws_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = off_w(DATA_W);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int MI_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);
  localparam logic [IDX_W:0] DEPTH_V =
    (IDX_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WS_V =
    WAIT_W'(WAIT_STATES);

  state_e state_q;
  state_e state_d;

  logic [IDX_W-1:0]  idx;
  logic [MI_W-1:0]   midx_q;
  logic              err;
  logic              err_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_rdata;
  logic [NB-1:0]     wbe;
  logic [WAIT_W-1:0] cnt_q;
  logic              setup;
  logic              ready;
  logic              done;
  logic              mem_we;

  assign idx   = IDX_W'(PADDR >> OFF_W);
  assign err   = ({1'b0, idx} >= DEPTH_V) ||
                 ((PADDR & OFF_MASK) != '0);
  assign setup = (state_q == IDLE) && PSEL && !PENABLE;
  assign ready = (state_q == ACCESS) && (cnt_q == '0);
  assign done  = ready && PSEL && PENABLE;
  assign mem_we = done && wr_q && !err_q;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: setup enters ACCESS, completion or deselect leaves
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (setup) state_d = ACCESS;
      end
      ACCESS: begin
        if (!PSEL)     state_d = IDLE;
        else if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the transfer at setup, count down wait states
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      midx_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else if (setup) begin
      midx_q  <= idx[MI_W-1:0];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
      err_q   <= err;
      cnt_q   <= WS_V;
      rdata_q <= (!PWRITE && !err) ? mem_rdata : '0;
    end else if (state_q == ACCESS) begin
      if (!PSEL) begin
        cnt_q <= '0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

`ifdef APB_SLAVE_WS_MEM_PSTRB_EN
  logic [NB-1:0] strb_q;

  // Strobes travel with the rest of the setup capture
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      strb_q <= '0;
    end else if (setup) begin
      strb_q <= PSTRB;
    end
  end

  assign wbe = strb_q;
`else
  logic unused_strb;

  assign unused_strb = ^PSTRB;
  assign wbe = '1;
`endif

  // Outputs decoded from registered state only
  always_comb begin
    PREADY  = ready;
    PRDATA  = (ready && !wr_q) ? rdata_q : '0;
    PSLVERR = ready ? err_q : 1'b0;
  end

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MI_W   (MI_W)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .widx  (midx_q),
    .wbe   (wbe),
    .wdata (wdata_q),
    .ridx  (idx[MI_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave_ws_mem.sv
// Bench for apb_slave_ws_mem: three instances with 0, 2 and 3
// wait states, vector table, corner sequences, random vs model.
module tb_apb_slave_ws_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [7:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    apb_slave_ws_mem #(
      .DATA_W      (32),
      .ADDR_W      (8),
      .DEPTH       (16),
      .WAIT_STATES (WS)
    ) u_dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PSTRB   (pstrb[g]),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  // Reference memory: one word array per instance
  logic [31:0] mdl [3][16];

  task automatic mdl_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        mdl[k][i] = '0;
  endtask

  task automatic mdl_step(input int k, input bit wr,
                          input logic [7:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          output logic [31:0] rd,
                          output bit err);
    int idx;
    idx = int'(a) / 4;
    err = (idx >= 16) || (int'(a) % 4 != 0);
    rd = err ? 32'h0 : mdl[k][idx];
    if (wr && !err) begin
`ifdef APB_SLAVE_WS_MEM_PSTRB_EN
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[k][idx][b*8 +: 8] = d[b*8 +: 8];
`else
      mdl[k][idx] = d;
`endif
    end
  endtask

  // One full transfer; starts just after a rising edge
  task automatic xfer(input int k, input bit wr,
                      input logic [7:0] a,
                      input logic [31:0] d,
                      input logic [3:0] s,
                      input logic [31:0] exp_rd,
                      input bit exp_err,
                      input bit wiggle);
    int lows;
    bit done;
    psel[k] = 1'b1;
    penable[k] = 1'b0;
    pwrite[k] = wr;
    paddr[k] = a;
    pwdata[k] = d;
    pstrb[k] = s;
    @(negedge clk);
    chk("setup_pready", k, 32'(pready[k]), 32'h0);
    @(posedge clk);
    #1 penable[k] = 1'b1;
    lows = 0;
    done = 1'b0;
    while (!done && lows < 20) begin
      @(negedge clk);
      if (pready[k]) begin
        chk("wait_cycles", k, 32'(lows), 32'(ws_of(k)));
        chk("prdata", k, prdata[k], wr ? 32'h0 : exp_rd);
        chk("pslverr", k, 32'(pslverr[k]), 32'(exp_err));
        done = 1'b1;
      end else begin
        lows++;
        if (wiggle) begin
          paddr[k] = 8'($urandom);
          pwdata[k] = $urandom;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("pready_timeout", k, 32'h0, 32'h1);
    psel[k] = 1'b0;
    penable[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          wiggle;
  } vec_t;

  function automatic vec_t mk(input int k, input bit wr,
                              input logic [7:0] a,
                              input logic [31:0] d,
                              input logic [3:0] s,
                              input logic [31:0] er,
                              input bit ee, input bit wg);
    vec_t v;
    v.k = k; v.wr = wr; v.a = a; v.d = d; v.s = s;
    v.exp_rd = er; v.exp_err = ee; v.wiggle = wg;
    return v;
  endfunction

  vec_t vec [15];

  initial begin
    logic [31:0] rd;
    bit er;
    bit wr;
    logic [7:0] a;

    for (int k = 0; k < 3; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0;
      paddr[k] = 0; pwdata[k] = 0; pstrb[k] = 0;
    end
    mdl_clear();

`ifdef APB_SLAVE_WS_MEM_PSTRB_EN
    vec[12] = mk(2, 0, 8'h14, 0, 4'hF, 32'hFF22FF44, 0, 0);
    vec[14] = mk(1, 0, 8'h08, 0, 4'hF, 32'h00000000, 0, 0);
`else
    vec[12] = mk(2, 0, 8'h14, 0, 4'hF, 32'h11223344, 0, 0);
    vec[14] = mk(1, 0, 8'h08, 0, 4'hF, 32'h00000055, 0, 0);
`endif
    vec[0]  = mk(0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    vec[1]  = mk(0, 0, 8'h04, 0, 4'hF, 32'hDEADBEEF, 0, 0);
    vec[2]  = mk(1, 0, 8'h00, 0, 4'hF, 32'h0, 0, 1);
    vec[3]  = mk(1, 1, 8'h40, 32'h1234, 4'hF, 0, 1, 0);
    vec[4]  = mk(1, 0, 8'h40, 0, 4'hF, 32'h0, 1, 0);
    vec[5]  = mk(1, 0, 8'h02, 0, 4'hF, 32'h0, 1, 0);
    vec[6]  = mk(0, 1, 8'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    vec[7]  = mk(0, 0, 8'h0C, 0, 4'hF, 32'hCAFEF00D, 0, 0);
    vec[8]  = mk(0, 1, 8'h10, 32'h0BADC0DE, 4'hF, 0, 0, 0);
    vec[9]  = mk(0, 0, 8'h10, 0, 4'hF, 32'h0BADC0DE, 0, 0);
    vec[10] = mk(2, 1, 8'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    vec[11] = mk(2, 1, 8'h14, 32'h11223344, 4'h5, 0, 0, 0);
    vec[13] = mk(1, 1, 8'h08, 32'h55, 4'h0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready", k, 32'(pready[k]), 32'h0);
      chk("rst_pslverr", k, 32'(pslverr[k]), 32'h0);
      chk("rst_prdata", k, prdata[k], 32'h0);
    end
    @(posedge clk);
    #1;

    // Table vectors, back-to-back with no idle cycles
    for (int i = 0; i < 15; i++) begin
      mdl_step(vec[i].k, vec[i].wr, vec[i].a, vec[i].d,
               vec[i].s, rd, er);
      xfer(vec[i].k, vec[i].wr, vec[i].a, vec[i].d,
           vec[i].s, vec[i].exp_rd, vec[i].exp_err,
           vec[i].wiggle);
    end

    // Abort: deselect in the second access cycle
    psel[2] = 1; penable[2] = 0; pwrite[2] = 1;
    paddr[2] = 8'h08; pwdata[2] = 32'hAA; pstrb[2] = 4'hF;
    @(posedge clk);
    #1 penable[2] = 1;
    @(negedge clk);
    chk("abort_pready1", 2, 32'(pready[2]), 32'h0);
    @(posedge clk);
    #1 psel[2] = 0; penable[2] = 0;
    @(negedge clk);
    chk("abort_pready2", 2, 32'(pready[2]), 32'h0);
    @(posedge clk);
    #1;
    mdl_step(2, 0, 8'h08, 0, 4'hF, rd, er);
    xfer(2, 0, 8'h08, 0, 4'hF, rd, er, 0);

    // Reset in the middle of an access phase
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1;
    paddr[0] = 8'h18; pwdata[0] = 32'h77; pstrb[0] = 4'hF;
    @(posedge clk);
    #1 penable[0] = 1;
    chk("pre_rst_pready", 0, 32'(pready[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_pready", 0, 32'(pready[0]), 32'h0);
    psel[0] = 0; penable[0] = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_clear();
    mdl_step(0, 0, 8'h04, 0, 4'hF, rd, er);
    xfer(0, 0, 8'h04, 0, 4'hF, rd, er, 0);
    mdl_step(0, 0, 8'h18, 0, 4'hF, rd, er);
    xfer(0, 0, 8'h18, 0, 4'hF, rd, er, 0);
    mdl_step(2, 0, 8'h14, 0, 4'hF, rd, er);
    xfer(2, 0, 8'h14, 0, 4'hF, rd, er, 0);

    // Random traffic against the reference memory
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        logic [31:0] d;
        logic [3:0] s;
        a = 8'($urandom_range(0, 8'h47));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        wr = 1'($urandom_range(0, 1));
        d = $urandom;
        s = 4'($urandom);
        mdl_step(k, wr, a, d, s, rd, er);
        xfer(k, wr, a, d, s, rd, er, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
